// File: rtl/key_debounce_enc_pkg.sv
// Shared types and key-code constants for the keypad front end.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} kstate_t;

  localparam logic [4:0] KEY_EQ  = 5'd16;
  localparam logic [4:0] KEY_MUL = 5'd17;
  localparam logic [4:0] KEY_ADD = 5'd18;
  localparam logic [4:0] KEY_SUB = 5'd19;
  localparam int         NKEYS_DEF = 20;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_debounce_enc_prienc.sv
// Combinational priority encoder: highest set key line wins.
module key_prienc #(
  parameter int NKEYS = 20
) (
  input  logic [NKEYS-1:0] keys_i,
  output logic [4:0]       code_o,
  output logic             any_o
);

  always_comb begin
    code_o = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (keys_i[i]) code_o = 5'(i);
    end
    any_o = |keys_i;
  end

endmodule

// File: rtl/key_debounce_enc.sv
// Keypad synchroniser, press/release debouncer and one-shot key strobe.
// Optional auto-repeat of hex digit keys is enabled with `define KEY_REPEAT_EN.
module key_debounce_enc
  import keypad_pkg::*;
#(
  parameter int NKEYS        = NKEYS_DEF,
  parameter int DEBOUNCE     = 3,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] in,
  output logic [4:0]       out,
  output logic             strobe,
  output logic             busy
);

  localparam int             CW = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0]  DB = CW'(DEBOUNCE);

  logic [NKEYS-1:0] s1_q, s_q;
  kstate_t          state_q, state_d;
  logic [4:0]       cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [4:0]       out_q, out_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic [4:0]       code;
  logic             any;

  key_prienc #(.NKEYS(NKEYS)) u_enc (
    .keys_i (s_q),
    .code_o (code),
    .any_o  (any)
  );

  // Saturating count so long stable periods never wrap back below DB.
  assign cnt_inc = (cnt_q == DB) ? cnt_q : cnt_q + 1'b1;

`ifdef KEY_REPEAT_EN
  localparam int            RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int            RW   = cnt_width(RMAX);
  localparam logic [RW-1:0] RD1  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR1  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rpt_q, rpt_d;
  logic          rep_q, rep_d;
`else
  logic unused_rpt;
  assign unused_rpt = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s_q      <= '0;
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_q    <= '0;
      rep_q    <= 1'b0;
`endif
    end else begin
      s1_q     <= in;
      s_q      <= s1_q;
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
`ifdef KEY_REPEAT_EN
      rpt_q    <= rpt_d;
      rep_q    <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
`ifdef KEY_REPEAT_EN
    rpt_d    = rpt_q;
    rep_d    = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (any) begin
          cand_d = code;
          if (DEBOUNCE <= 1) begin
            out_d    = code;
            strobe_d = 1'b1;
            busy_d   = 1'b1;
            cnt_d    = '0;
            state_d  = HELD;
`ifdef KEY_REPEAT_EN
            rpt_d    = '0;
            rep_d    = 1'b0;
`endif
          end else begin
            cnt_d   = CW'(1);
            state_d = PRESS;
          end
        end
      end
      PRESS: begin
        if (!any) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (code != cand_q) begin
          cand_d = code;
          cnt_d  = CW'(1);
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB) begin
            out_d    = cand_q;
            strobe_d = 1'b1;
            busy_d   = 1'b1;
            cnt_d    = '0;
            state_d  = HELD;
`ifdef KEY_REPEAT_EN
            rpt_d    = '0;
            rep_d    = 1'b0;
`endif
          end
        end
      end
      HELD: begin
        if (!any) begin
          if (DEBOUNCE <= 1) begin
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = CW'(1);
            state_d = RELEASE;
          end
        end else begin
`ifdef KEY_REPEAT_EN
          // Only hex digits repeat; the first gap is the long delay, then the rate.
          if (out_q < KEY_EQ) begin
            if ((!rep_q && rpt_q == RD1) || (rep_q && rpt_q == RR1)) begin
              strobe_d = 1'b1;
              rpt_d    = '0;
              rep_d    = 1'b1;
            end else if (rpt_q != '1) begin
              rpt_d = rpt_q + 1'b1;
            end
          end
`endif
        end
      end
      RELEASE: begin
        if (any) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB) begin
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out    = out_q;
  assign strobe = strobe_q;
  assign busy   = busy_q;

endmodule
